// File: rtl/acc_drain_stage.sv
// acc_drain_stage: double-buffered capture of a mesh accumulator tile, drained as row beats over valid/ready.
// Define ACC_DRAIN_TRANSPOSE_EN to emit columns instead of rows (C^T writeback).
module acc_drain_stage #(
   parameter int MESH_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_ni,
   input  logic                                                 clear_i,
   input  logic                                                 capture_i,
   input  logic [MESH_WIDTH-1:0][MESH_WIDTH-1:0][DATA_WIDTH-1:0] acc_data_i,
   output logic                                                 capture_ready_o,
   output logic                                                 row_valid_o,
   input  logic                                                 row_ready_i,
   output logic [MESH_WIDTH*DATA_WIDTH-1:0]                     row_data_o,
   output logic [$clog2(MESH_WIDTH)-1:0]                        row_idx_o,
   output logic                                                 last_o,
   output logic                                                 busy_o
);
   localparam int RW = $clog2(MESH_WIDTH);
   localparam logic [RW-1:0] LAST_ROW = RW'(MESH_WIDTH - 1);
   if (MESH_WIDTH < 2) begin : g_bad_width
      $error("acc_drain_stage: MESH_WIDTH must be >= 2");
   end
   logic [1:0][MESH_WIDTH-1:0][MESH_WIDTH-1:0][DATA_WIDTH-1:0] bufs;
   logic [1:0]    full;
   logic          wr_sel, rd_sel;
   logic [RW-1:0] rd_row;
   logic          xfer, last;
   assign capture_ready_o = !full[wr_sel];
   assign row_valid_o     = full[rd_sel];
   assign row_idx_o       = rd_row;
   assign last            = row_valid_o && (rd_row == LAST_ROW);
   assign last_o          = last;
   assign busy_o          = |full;
   assign xfer            = row_valid_o && row_ready_i;
`ifdef ACC_DRAIN_TRANSPOSE_EN
   always_comb begin
      row_data_o = '0;
      for (int i = 0; i < MESH_WIDTH; i++) row_data_o[DATA_WIDTH*i +: DATA_WIDTH] = bufs[rd_sel][i][rd_row];
   end
`else
   assign row_data_o = bufs[rd_sel][rd_row];
`endif
   // capture targets an empty buffer and drain a full one, so the two never touch the same flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bufs   <= '0;
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         rd_row <= '0;
      end else if (clear_i) begin
         bufs   <= '0;
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         rd_row <= '0;
      end else begin
         if (capture_i && capture_ready_o) begin
            bufs[wr_sel] <= acc_data_i;
            full[wr_sel] <= 1'b1;
            wr_sel       <= ~wr_sel;
         end
         if (xfer) begin
            rd_row <= last ? '0 : rd_row + 1'b1;
            if (last) begin
               full[rd_sel] <= 1'b0;
               rd_sel       <= ~rd_sel;
            end
         end
      end
   end
endmodule

// File: doc/acc_drain_stage.md
Name: acc_drain_stage

Overview:
- Result-side counterpart of the mesh weight-load stage: captures a full MESH_WIDTH x MESH_WIDTH accumulator snapshot from the systolic mesh in one cycle.
- Serializes the snapshot into MESH_WIDTH row beats of MESH_WIDTH*DATA_WIDTH bits over a valid/ready interface toward the register-file/LSU writeback path.
- Double-buffered, so the mesh can hand over the next tile while the previous tile is still draining.

Parameters:
- MESH_WIDTH, 4, mesh rows/columns; must be >= 2 (elaboration $error otherwise).
- DATA_WIDTH, 32, bits per accumulator element.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush of both buffers and the drain state.
- capture_i  in  1  mesh presents a valid snapshot on acc_data_i.
- acc_data_i  in  [MESH_WIDTH][MESH_WIDTH][DATA_WIDTH]  snapshot, indexed [row][col].
- capture_ready_o  out  1  a free buffer exists; capture accepted this cycle.
- row_valid_o  out  1  row beat valid.
- row_ready_i  in  1  writeback accepts the beat.
- row_data_o  out  MESH_WIDTH*DATA_WIDTH  packed row; element col jj at bits [DATA_WIDTH*jj +: DATA_WIDTH].
- row_idx_o  out  $clog2(MESH_WIDTH)  index of the row currently presented.
- last_o  out  1  current beat is the final row of the tile.
- busy_o  out  1  at least one buffer is full.

Behaviour:
- State:
  - Two buffers, buf0 and buf1, each with a full flag.
  - wr_sel and rd_sel, each 1 bit.
  - rd_row counter, $clog2(MESH_WIDTH) bits.
- Reset: all flags, pointers, counters and buffer contents are 0. Resulting outputs:
  - capture_ready_o = 1.
  - row_valid_o = 0, last_o = 0, busy_o = 0.
  - row_idx_o = 0, row_data_o = 0.
- capture_ready_o = !full[wr_sel], computed from registered state only.
  - A buffer freed in cycle N is capturable from cycle N+1; there is no same-cycle bypass.
- Capture:
  - capture_i && capture_ready_o: buf[wr_sel] <= acc_data_i, full[wr_sel] <= 1, wr_sel toggles.
  - capture_i && !capture_ready_o: snapshot is dropped and no state changes. Upstream must respect capture_ready_o.
- Per-buffer states: EMPTY and FULL.
- Reader states: IDLE (full[rd_sel] = 0) and DRAIN (full[rd_sel] = 1).
- Outputs:
  - row_valid_o = full[rd_sel].
  - row_data_o = buf[rd_sel][rd_row].
  - row_idx_o = rd_row.
  - last_o = row_valid_o && (rd_row == MESH_WIDTH-1).
  - busy_o = full[0] | full[1].
  - All outputs derive from registers only; there is no combinational path from row_ready_i.
- Handshake:
  - Beat transfers when row_valid_o && row_ready_i.
  - While row_valid_o = 1 and row_ready_i = 0, row_data_o, row_idx_o and last_o hold stable.
- On a transfer:
  - If not last: rd_row increments.
  - If last: rd_row wraps to 0, full[rd_sel] clears, rd_sel toggles.
- Latency: capture in cycle N into an empty stage gives row_valid_o = 1 with row 0 in cycle N+1.
  - With row_ready_i held high, a tile drains in MESH_WIDTH consecutive cycles.
  - Back-to-back tiles drain with no bubble between them.
- Simultaneous capture and last-beat transfer: both take effect.
  - The capture targets wr_sel, which is necessarily the other buffer or an empty one.
  - The drain moves to the next buffer in the same edge.
- Ordering: tiles are emitted in capture order (FIFO depth 2).
- clear_i has priority over capture and handshake. Next cycle:
  - full flags, wr_sel, rd_sel and rd_row are 0.
  - Buffer data is zeroed.
  - A beat presented during the clear cycle is treated as not transferred, even if row_ready_i = 1.
- Async reset mid-drain returns all state to reset values immediately.

Optional Feature:
- Macro ACC_DRAIN_TRANSPOSE_EN.
- When defined: each beat carries a column instead of a row.
  - row_data_o lane ii = buf[rd_sel][ii][rd_row].
  - row_idx_o is the column index.
  - This supports storing C^T without a separate transpose pass.
- When undefined: row order as above, and no transpose logic is elaborated.
- Handshake, latency and all other behaviour are identical in both builds.

Test Plan:
1. Reset: rst_ni low, then release -> capture_ready_o = 1, row_valid_o = 0, busy_o = 0, row_idx_o = 0, row_data_o = 0.
2. Single tile, MESH_WIDTH = 4, acc[i][j] = 16*i + j, row_ready_i = 1, capture in cycle N -> cycles N+1..N+4 show row_idx 0..3, lane jj of beat i = 16*i + j, last_o only at idx 3, and row_valid_o = 0 at N+5.
3. Backpressure: row_ready_i = 0 for 3 cycles while row 1 is presented -> row_idx_o = 1, data 0x10..0x13 and last_o = 0 stay stable; drain resumes at row 2 when ready rises.
4. Double-buffer full, row_ready_i = 0:
   - Captures of tile A (values 0x100+) then tile B (0x200+) -> capture_ready_o = 0 after B.
   - A third capture C is dropped.
   - Raising ready emits A rows 0..3 then B rows 0..3 with no gap.
   - capture_ready_o returns to 1 the cycle after A's last beat.
5. clear_i during row 2 of a tile with a second tile pending, row_ready_i = 1 -> that beat is not counted; next cycle row_valid_o = 0, busy_o = 0, capture_ready_o = 1, row_idx_o = 0, and a fresh capture drains from row 0.
6. With ACC_DRAIN_TRANSPOSE_EN, same tile as test 2 -> beat k lane ii = 16*ii + k (e.g. beat 1 = 0x01, 0x11, 0x21, 0x31), last_o at beat 3.
